// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants, state encoding and request legality check for the
// RISC-V load/store controller in front of ram256x32.
package mem_access_ctrl_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic RAM_SEL   = 1'b0;
   localparam logic RAM_DESEL = 1'b1;
   localparam logic RW_READ   = 1'b0;
   localparam logic RW_WRITE  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // Illegal width code, unsigned store, or misaligned halfword/word.
   function automatic logic req_illegal(input logic [2:0] f3, input logic we,
                                        input logic [1:0] lane);
      logic bad;
      case (f3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = lane[0];
         F3_W:    bad = (lane != 2'b00);
         F3_BU:   bad = we;
         F3_HU:   bad = we || lane[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between the datapath (master) and the
// load/store controller (slave).
interface mem_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/mem_access_ctrl_byte_lane_align.sv
// Combinational lane logic: load extract/extend and SB/SH merge of new
// store bytes into the word just read from RAM.
module byte_lane_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] rdata,
   input  logic [15:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   assign sel_byte = rdata[{lane, 3'b000} +: 8];
   assign sel_half = lane[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      load_data = 32'h0;
      case (funct3)
         F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   load_data = {24'h0, sel_byte};
         F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
         F3_HU:   load_data = {16'h0, sel_half};
         F3_W:    load_data = rdata;
         default: load_data = 32'h0;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic byte_hit;
         assign byte_hit = ((funct3 == F3_B) && (lane == 2'(gi))) ||
                           ((funct3 == F3_H) && (lane[1] == 1'(gi / 2)));
         // Halfword stores spread wdata[15:0] over two lanes; byte stores reuse wdata[7:0].
         assign merged_word[gi*8 +: 8] = !byte_hit ? rdata[gi*8 +: 8] :
                                         (funct3 == F3_H) ? wdata[(gi % 2)*8 +: 8] :
                                         wdata[7:0];
      end
   endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller driving ram256x32: one request per handshake,
// read-modify-write for SB/SH, errors answered without touching the RAM.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int          ADDR_BITS = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_access_ctrl_if.slave     bus,
   output logic                 ram_cs,
   output logic                 ram_rw,
   output logic [ADDR_BITS-1:0] ram_adrs,
   output logic [31:0]          ram_wdata,
   input  logic [31:0]          ram_rdata
);
   state_t                 state_reg, state_next;
   logic                   we_reg, we_next;
   logic [2:0]             f3_reg, f3_next;
   logic [1:0]             lane_reg, lane_next;
   logic [15:0]            wdata_reg, wdata_next;
   logic                   cs_reg, cs_next;
   logic                   rw_reg, rw_next;
   logic [ADDR_BITS-1:0]   adrs_reg, adrs_next;
   logic [31:0]            ram_wdata_reg, ram_wdata_next;
   logic                   resp_valid_reg, resp_valid_next;
   logic [31:0]            resp_rdata_reg, resp_rdata_next;
   logic                   resp_err_reg, resp_err_next;
   logic                   req_ready_reg, req_ready_next;

   logic [31:0] off;
   logic        out_of_range;
   logic        req_err;
   logic        accept;
   logic [31:0] load_data;
   logic [31:0] merged_word;

   assign off          = bus.req_addr - BASE_ADDR;
   assign out_of_range = (bus.req_addr < BASE_ADDR) || ((off >> (ADDR_BITS + 2)) != 32'd0);
   assign req_err      = out_of_range || req_illegal(bus.req_funct3, bus.req_we, off[1:0]);
   assign accept       = bus.req_valid && req_ready_reg;

   byte_lane_align u_align (
      .funct3      (f3_reg),
      .lane        (lane_reg),
      .rdata       (ram_rdata),
      .wdata       (wdata_reg),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   always_comb begin
      state_next      = state_reg;
      we_next         = we_reg;
      f3_next         = f3_reg;
      lane_next       = lane_reg;
      wdata_next      = wdata_reg;
      cs_next         = cs_reg;
      rw_next         = rw_reg;
      adrs_next       = adrs_reg;
      ram_wdata_next  = ram_wdata_reg;
      resp_valid_next = resp_valid_reg;
      resp_rdata_next = resp_rdata_reg;
      resp_err_next   = resp_err_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               we_next         = bus.req_we;
               f3_next         = bus.req_funct3;
               lane_next       = off[1:0];
               wdata_next      = bus.req_wdata[15:0];
               resp_rdata_next = 32'h0;
               resp_err_next   = 1'b0;
               if (req_err) begin
                  state_next      = ST_RESP;
                  resp_valid_next = 1'b1;
                  resp_err_next   = 1'b1;
               end else if (!bus.req_we || (bus.req_funct3 != F3_W)) begin
                  // Loads and partial stores both start with a read of the word.
                  state_next = ST_RD;
                  cs_next    = RAM_SEL;
                  rw_next    = RW_READ;
                  adrs_next  = off[ADDR_BITS+1:2];
               end else begin
                  state_next     = ST_WR;
                  cs_next        = RAM_SEL;
                  rw_next        = RW_WRITE;
                  adrs_next      = off[ADDR_BITS+1:2];
                  ram_wdata_next = bus.req_wdata;
               end
            end
         end
         ST_RD: begin
            if (we_reg) begin
               state_next     = ST_WR;
               rw_next        = RW_WRITE;
               ram_wdata_next = merged_word;
            end else begin
               state_next      = ST_RESP;
               cs_next         = RAM_DESEL;
               resp_valid_next = 1'b1;
               resp_rdata_next = load_data;
            end
         end
         ST_WR: begin
            state_next      = ST_RESP;
            cs_next         = RAM_DESEL;
            resp_valid_next = 1'b1;
         end
         ST_RESP: begin
            // rw falls back to read only here, with the RAM already deselected.
            if (bus.resp_ready) begin
               state_next      = ST_IDLE;
               resp_valid_next = 1'b0;
               rw_next         = RW_READ;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      req_ready_next = (state_next == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         we_reg         <= 1'b0;
         f3_reg         <= 3'b000;
         lane_reg       <= 2'b00;
         wdata_reg      <= 16'h0;
         cs_reg         <= RAM_DESEL;
         rw_reg         <= RW_READ;
         adrs_reg       <= '0;
         ram_wdata_reg  <= 32'h0;
         resp_valid_reg <= 1'b0;
         resp_rdata_reg <= 32'h0;
         resp_err_reg   <= 1'b0;
         req_ready_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         we_reg         <= we_next;
         f3_reg         <= f3_next;
         lane_reg       <= lane_next;
         wdata_reg      <= wdata_next;
         cs_reg         <= cs_next;
         rw_reg         <= rw_next;
         adrs_reg       <= adrs_next;
         ram_wdata_reg  <= ram_wdata_next;
         resp_valid_reg <= resp_valid_next;
         resp_rdata_reg <= resp_rdata_next;
         resp_err_reg   <= resp_err_next;
         req_ready_reg  <= req_ready_next;
      end
   end

   assign ram_cs         = cs_reg;
   assign ram_rw         = rw_reg;
   assign ram_adrs       = adrs_reg;
   assign ram_wdata      = ram_wdata_reg;
   assign bus.req_ready  = req_ready_reg;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_rdata = resp_rdata_reg;
   assign bus.resp_err   = resp_err_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: requests push expected responses; a negedge monitor
// pops and compares them, plus RAM protocol and reset checks.
module tb_mem_access_ctrl;
   import mem_access_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_ctrl_if bus();
   logic        ram_cs, ram_rw;
   logic [7:0]  ram_adrs;
   logic [31:0] ram_wdata, ram_rdata;
   logic [31:0] mem [256];
   bit          clear_mem = 1'b1;

   mem_access_ctrl #(.ADDR_BITS(8), .BASE_ADDR(32'h0)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .ram_cs    (ram_cs),
      .ram_rw    (ram_rw),
      .ram_adrs  (ram_adrs),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // Behavioural ram256x32: synchronous write, combinational read.
   always @(posedge clk) begin
      if (clear_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      end else if (ram_cs == 1'b0 && ram_rw == 1'b1) begin
         mem[ram_adrs] <= ram_wdata;
      end
   end
   assign ram_rdata = (ram_cs == 1'b0 && ram_rw == 1'b0) ? mem[ram_adrs] : 32'h0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          start;
      int          lat;
   } exp_t;
   exp_t sb_q[$];
   exp_t cur;
   bit   active   = 1'b0;
   bit   have_exp = 1'b0;
   int   cs_low   = 0;
   logic       prev_rw   = 1'b0;
   logic [7:0] prev_adrs = 8'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ram_cs == 1'b0) cs_low++;
      if (prev_rw && ram_rw) check("adrs_stable_while_rw", 32'(ram_adrs), 32'(prev_adrs));
      prev_rw   = ram_rw;
      prev_adrs = ram_adrs;
      if (rst) begin
         active = 1'b0;
      end else if (bus.resp_valid) begin
         if (!active) begin
            active = 1'b1;
            if (sb_q.size() == 0) begin
               have_exp = 1'b0;
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_resp: got resp_valid=1, expected no response");
            end else begin
               have_exp = 1'b1;
               cur = sb_q.pop_front();
               check("latency", 32'(cyc - cur.start), 32'(cur.lat));
               $display("[TB] resp rdata=%08h err=%0d", bus.resp_rdata, bus.resp_err);
            end
         end
         if (have_exp) begin
            check("resp_rdata", bus.resp_rdata, cur.rdata);
            check("resp_err", 32'(bus.resp_err), 32'(cur.err));
         end
         if (bus.resp_ready) active = 1'b0;
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input bit expect_resp,
                        output int start);
      exp_t e;
      int   n = 0;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      start = cyc;
      if (bus.req_ready !== 1'b1) begin
         tests++;
         fails++;
         $display("[TB] FAIL accept_timeout: got req_ready=%b, expected 1", bus.req_ready);
         bus.req_valid = 1'b0;
         return;
      end
      if (expect_resp) begin
         e.rdata = exp_rdata;
         e.err   = exp_err;
         e.start = start;
         e.lat   = exp_lat;
         sb_q.push_back(e);
      end
      $display("[TB] req we=%0d f3=%03b addr=%08h wdata=%08h exp rdata=%08h err=%0d lat=%0d",
               we, f3, addr, wdata, exp_rdata, exp_err, exp_lat);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb_q.size() != 0 || bus.resp_valid) && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0 || bus.resp_valid) begin
         tests++;
         fails++;
         $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
      end
   endtask

   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input int exp_lat);
      int s;
      issue(we, f3, addr, wdata, exp_rdata, exp_err, exp_lat, 1'b1, s);
      wait_idle();
   endtask

   initial begin
      int s1, s2, c0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.resp_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ram_cs", 32'(ram_cs), 32'd1);
      check("rst_ram_rw", 32'(ram_rw), 32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;
      clear_mem = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

      txn(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
      check("ram_word4_sw", mem[4], 32'hDEADBEEF);
      issue(1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, s1);
      issue(1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, s2);
      wait_idle();
      check("b2b_spacing", 32'(s2 - s1), 32'd3);

      txn(1'b1, F3_B, 32'h11, 32'hFFFFFF80, 32'h0, 1'b0, 3);
      check("ram_word4_sb", mem[4], 32'hDEAD80EF);
      txn(1'b0, F3_B,  32'h11, 32'h0, 32'hFFFFFF80, 1'b0, 2);
      txn(1'b0, F3_BU, 32'h11, 32'h0, 32'h00000080, 1'b0, 2);
      txn(1'b1, F3_H, 32'h12, 32'hABCD1234, 32'h0, 1'b0, 3);
      check("ram_word4_sh", mem[4], 32'h123480EF);
      txn(1'b0, F3_H,  32'h12, 32'h0, 32'h00001234, 1'b0, 2);
      txn(1'b0, F3_H,  32'h10, 32'h0, 32'hFFFF80EF, 1'b0, 2);
      txn(1'b0, F3_B,  32'h13, 32'h0, 32'h00000012, 1'b0, 2);
      txn(1'b0, F3_BU, 32'h10, 32'h0, 32'h000000EF, 1'b0, 2);
      txn(1'b0, F3_B,  32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 2);

      c0 = cs_low;
      txn(1'b0, F3_HU, 32'h13,  32'h0, 32'h0, 1'b1, 1);
      txn(1'b0, F3_W,  32'h400, 32'h0, 32'h0, 1'b1, 1);
      txn(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
      txn(1'b1, F3_BU, 32'h10,  32'h55, 32'h0, 1'b1, 1);
      txn(1'b0, F3_W,  32'h12,  32'h0, 32'h0, 1'b1, 1);
      check("err_no_ram_access", 32'(cs_low), 32'(c0));
      check("err_ram_untouched", mem[4], 32'h123480EF);

      txn(1'b1, F3_W, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0, 2);
      txn(1'b0, F3_W, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0, 2);
      check("ram_word255", mem[255], 32'hCAFEF00D);

      issue(1'b1, F3_W, 32'h20, 32'h55AA55AA, 32'h0, 1'b0, 2, 1'b0, s1);
      check("midop_in_wr_cs", 32'(ram_cs), 32'd0);
      check("midop_in_wr_rw", 32'(ram_rw), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("midop_rst_cs", 32'(ram_cs), 32'd1);
      check("midop_rst_rw", 32'(ram_rw), 32'd0);
      check("midop_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("midop_idle_req_ready", 32'(bus.req_ready), 32'd1);
      check("midop_no_resp", 32'(bus.resp_valid), 32'd0);

      bus.resp_ready = 1'b0;
      issue(1'b0, F3_W, 32'h10, 32'h0, 32'h123480EF, 1'b0, 2, 1'b1, s1);
      for (int n = 0; n < 10 && !bus.resp_valid; n++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("stall_resp_held", 32'(bus.resp_valid), 32'd1);
      bus.resp_ready = 1'b1;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
